// File: rtl/seqmul_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
// The early-zero shortcut is enabled by defining SEQMUL_EARLY_ZERO_EN.
package seqmul_pkg;
  localparam int SEQMUL_WIDTH = 8;
  localparam int ST_W         = 3;

  typedef logic [ST_W-1:0] seqmul_state_t;

  localparam seqmul_state_t IDLE  = 3'd0;
  localparam seqmul_state_t LOAD  = 3'd1;
  localparam seqmul_state_t CHECK = 3'd2;
  localparam seqmul_state_t TEST  = 3'd3;
  localparam seqmul_state_t ADD   = 3'd4;
  localparam seqmul_state_t SHIFT = 3'd5;
  localparam seqmul_state_t DONE  = 3'd6;
endpackage

// File: rtl/seqmul_ctrl.sv
// Multiplier controller FSM. busy/done are registered one edge behind the state.
// SEQMUL_EARLY_ZERO_EN lets CHECK jump straight to DONE on a zero operand.
module seqmul_ctrl
  import seqmul_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic finish,
  input  logic q0,
  input  logic zero_op,
  input  logic cnt_last,
  output logic load,
  output logic clr,
  output logic add,
  output logic shift,
  output logic busy,
  output logic done,
  output logic early_done
);
`ifdef SEQMUL_EARLY_ZERO_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  seqmul_state_t r_state, w_next;
  logic          r_busy, r_done;
  logic          w_fin_ack;

  // finish is only honoured once done is actually visible to the requester
  assign w_fin_ack  = (r_state == DONE) && r_done && finish;
  assign load       = (r_state == IDLE) && start;
  assign clr        = (r_state == LOAD);
  assign add        = (r_state == ADD);
  assign shift      = (r_state == SHIFT);
  assign early_done = (r_state == CHECK) && zero_op && EARLY_EN;
  assign busy       = r_busy;
  assign done       = r_done;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    w_next = CHECK;
      CHECK:   w_next = early_done ? DONE : TEST;
      TEST:    w_next = q0 ? ADD : SHIFT;
      ADD:     w_next = SHIFT;
      SHIFT:   w_next = cnt_last ? DONE : TEST;
      DONE:    if (w_fin_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (r_state != IDLE) && !w_fin_ack;
      r_done  <= (r_state == DONE) && !w_fin_ack;
    end
  end
endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier datapath: {A,Q} accumulates the product over WIDTH iterations.
// Define SEQMUL_EARLY_ZERO_EN to finish immediately when an operand is zero.
module seq_multiplier
  import seqmul_pkg::*;
#(
  parameter int WIDTH = SEQMUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               finish,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               overflow,
  output logic               zero_op
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_m, r_q, r_a;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_overflow, r_zero_op;

  logic             w_load, w_clr, w_add, w_shift, w_early_done, w_cnt_last;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_a_shift;

  assign w_sum      = {1'b0, r_a} + {1'b0, r_m};
  assign w_a_shift  = {r_c, r_a[WIDTH-1:1]};
  assign w_cnt_last = (r_cnt == CW'(WIDTH - 1));

  seqmul_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .finish     (finish),
    .q0         (r_q[0]),
    .zero_op    (r_zero_op),
    .cnt_last   (w_cnt_last),
    .load       (w_load),
    .clr        (w_clr),
    .add        (w_add),
    .shift      (w_shift),
    .busy       (busy),
    .done       (done),
    .early_done (w_early_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m        <= '0;
      r_q        <= '0;
      r_a        <= '0;
      r_c        <= 1'b0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
      r_zero_op  <= 1'b0;
    end else begin
      if (w_load) begin
        r_m <= a_in;
        r_q <= b_in;
      end
      if (w_clr) begin
        r_a        <= '0;
        r_c        <= 1'b0;
        r_cnt      <= '0;
        r_overflow <= 1'b0;
        r_zero_op  <= (r_m == '0) || (r_q == '0);
      end
      if (w_add) {r_c, r_a} <= w_sum;
      // last shift: the high half is final, so the overflow flag is captured here
      if (w_shift) begin
        r_c   <= 1'b0;
        r_a   <= w_a_shift;
        r_q   <= {r_a[0], r_q[WIDTH-1:1]};
        r_cnt <= r_cnt + 1'b1;
        if (w_cnt_last) r_overflow <= |w_a_shift;
      end
      // skipped iterations would have shifted Q out completely
      if (w_early_done) begin
        r_q        <= '0;
        r_overflow <= 1'b0;
      end
    end
  end

  assign product  = {r_a, r_q};
  assign overflow = r_overflow;
  assign zero_op  = r_zero_op;
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential unsigned shift-add multiplier with an integrated controller/datapath. It is the multiply-direction companion to the team's restoring divider and uses the same start / hold-until-acknowledged result handshake, so one top-level sequencer can drive both blocks. It accepts two WIDTH-bit operands and returns a 2·WIDTH-bit product, with flags for overflow (product exceeds WIDTH bits) and zero operand.

## Interface
- WIDTH, 8, operand width in bits; product is 2·WIDTH bits.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  multiplicand; latched on the accepting edge.
- b_in  input  WIDTH  multiplier; latched on the accepting edge.
- finish  input  1  acknowledge; sampled only in DONE.
- busy  output  1  high in every state except IDLE.
- done  output  1  high in DONE only.
- product  output  2·WIDTH  {A,Q}; valid while done is high.
- overflow  output  1  in DONE: upper WIDTH product bits are nonzero.
- zero_op  output  1  in DONE: a or b was zero.

## Operation
- Registers: M (WIDTH), Q (WIDTH), A (WIDTH), carry C (1), counter Cn (clog2(WIDTH+1) bits).
- IDLE: start=1 latches M←a_in and Q←b_in, then go to LOAD. Otherwise stay in IDLE.
- LOAD: A←0, C←0, Cn←0, zero_op←(M==0 or Q==0); go to CHECK.
- CHECK: go to DONE if zero_op and SEQMUL_EARLY_ZERO_EN is defined; otherwise go to TEST.
- TEST: Q[0]=1 goes to ADD; otherwise goes to SHIFT.
- ADD: {C,A}←A+M, computed at WIDTH+1 bits with no truncation; go to SHIFT.
- SHIFT: {C,A,Q}←{1'b0,C,A,Q[WIDTH-1:1]}, a logical right shift; Cn←Cn+1. Go to DONE if Cn+1==WIDTH, else go to TEST.
- DONE: product, overflow and zero_op are held stable. finish=1 returns to IDLE.
- overflow is computed as (A!=0) when entering DONE.
- start outside IDLE is ignored. finish outside DONE is ignored.
- Operand input changes after the accepting edge have no effect on the operation in flight.
- Reset values, in any state: state=IDLE; busy, done, overflow and zero_op are 0; product is 0; M, Q, A, C and Cn are 0.
- Reset mid-operation aborts the operation; no result is produced.

## Timing
- Edge 0 is the edge that samples start=1 in IDLE.
- Full run: done is first high after 3+2·WIDTH+popcount(b) edges.
- Early-zero run (macro defined, zero operand): done is high after 3 edges.
- busy rises one edge after start is accepted.
- busy and done fall on the edge that samples finish=1 in DONE.
- A new start can be accepted on the edge after the return to IDLE. Minimum spacing between operations is one IDLE cycle.
- rst takes effect on the next rising edge, with no bypass to outputs.
- In DONE, rst and finish asserted together resolve as reset (same end state).

## Configuration
- SEQMUL_EARLY_ZERO_EN defined: CHECK skips directly to DONE when either operand is zero. product=0, zero_op=1, overflow=0, latency 3 edges.
- SEQMUL_EARLY_ZERO_EN undefined: every operation runs all WIDTH iterations. zero_op is still reported, and product=0 is still correct.

## Structure
- Package seqmul_pkg: state typedef with IDLE, LOAD, CHECK, TEST, ADD, SHIFT, DONE; a state-width constant; the default WIDTH constant.
- Sub-module seqmul_ctrl holds the FSM:
  - inputs: start, finish, q0, zero_op, cnt_last;
  - outputs: load, clr, add, shift, busy, done, early_done.
- The top level holds the datapath registers.

## Test plan
- 13×11, WIDTH=8: product 0x008F, overflow=0, zero_op=0; done high after edge 22.
- 255×255: product 0xFE01, overflow=1; done high after edge 27.
- 0×0x5A: product 0, zero_op=1, overflow=0. Done high after edge 3 with the macro defined, after edge 23 without it.
- Run 200×3 (product 0x0258), then hold finish=0 for 10 cycles: done, product and overflow stay stable. A one-cycle finish pulse returns the block to IDLE on the next edge, with busy=0.
- Assert rst during ADD of bit 3 of 0xFF×0xFF:
  - all outputs and registers read 0 on the next edge;
  - a following 6×7 run yields 0x002A.
- Inputs changing during an operation: start asserted and a_in/b_in changed mid-operation are ignored; 9×9 still yields 0x0051, with exactly one done episode.
